// File: rtl/mult_booth_acc_pkg.sv
// Shared definitions for the Booth multiplier accumulation stage: state
// encoding and the accumulator/counter width derivations.
package mult_booth_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic int acc_width(input int data_width, input int guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

  function automatic int cnt_width(input int guard_bits);
    return guard_bits + 1;
  endfunction

endpackage

// File: rtl/mult_booth_acc_add.sv
// Combinational sign-extending adder with signed overflow detect.
module mult_booth_acc_add #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [IN_WIDTH-1:0]  addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [ACC_WIDTH-1:0] w_ext;

  assign w_ext = {{(ACC_WIDTH - IN_WIDTH){addend[IN_WIDTH-1]}}, addend};
  assign sum   = acc + w_ext;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf   = (acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

endmodule

// File: rtl/mult_booth_acc.sv
// Frame accumulator for signed Booth products: sums each i_last-delimited
// frame and holds the result, term count and sticky overflow until taken.
//
// state    | meaning
// ST_ACCUM | accepting products (o_ready=1 once out of reset)
// ST_HOLD  | result presented (o_valid=1), waiting for i_ready
module mult_booth_acc
  import mult_booth_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GUARD_BITS = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_clr,
  input  logic [2*DATA_WIDTH-1:0]            iv_prod,
  input  logic                               i_valid,
  input  logic                               i_last,
  output logic                               o_ready,
  output logic [2*DATA_WIDTH+GUARD_BITS-1:0] ov_sum,
  output logic [GUARD_BITS:0]                ov_count,
  output logic                               o_ovf,
  output logic                               o_valid,
  input  logic                               i_ready
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, GUARD_BITS);
  localparam int CNT_WIDTH  = cnt_width(GUARD_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state, w_state_d;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_d;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                 r_ovf, w_ovf_d;
  logic [ACC_WIDTH-1:0] r_sum, w_sum_d;
  logic [CNT_WIDTH-1:0] r_count, w_count_d;
  logic                 r_oovf, w_oovf_d;
  logic                 r_valid, w_valid_d;
  logic                 r_ready, w_ready_d;

  logic [ACC_WIDTH-1:0] w_add_sum;
  logic                 w_add_ovf;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_accept;

  mult_booth_acc_add #(
    .IN_WIDTH  (PROD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .acc    (r_acc),
    .addend (iv_prod),
    .sum    (w_add_sum),
    .ovf    (w_add_ovf)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
  // r_ready is low for the first cycle after reset, so it gates accepts too.
  assign w_accept  = i_valid && r_ready && (r_state == ST_ACCUM);

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_ovf_d   = r_ovf;
    w_sum_d   = r_sum;
    w_count_d = r_count;
    w_oovf_d  = r_oovf;
    w_valid_d = r_valid;
    w_ready_d = r_ready;

    if (i_clr) begin
      w_state_d = ST_ACCUM;
      w_acc_d   = '0;
      w_cnt_d   = '0;
      w_ovf_d   = 1'b0;
      w_valid_d = 1'b0;
      w_ready_d = 1'b1;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          w_ready_d = 1'b1;
          if (w_accept) begin
            if (i_last) begin
              w_sum_d   = w_add_sum;
              w_count_d = w_cnt_inc;
              w_oovf_d  = r_ovf | w_add_ovf;
              w_valid_d = 1'b1;
              w_ready_d = 1'b0;
              w_acc_d   = '0;
              w_cnt_d   = '0;
              w_ovf_d   = 1'b0;
              w_state_d = ST_HOLD;
            end else begin
              w_acc_d = w_add_sum;
              w_cnt_d = w_cnt_inc;
              w_ovf_d = r_ovf | w_add_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            w_valid_d = 1'b0;
            w_ready_d = 1'b1;
            w_state_d = ST_ACCUM;
          end
        end
        default: begin
          w_state_d = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_sum   <= '0;
      r_count <= '0;
      r_oovf  <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_ovf   <= w_ovf_d;
      r_sum   <= w_sum_d;
      r_count <= w_count_d;
      r_oovf  <= w_oovf_d;
      r_valid <= w_valid_d;
      r_ready <= w_ready_d;
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign ov_sum   = r_sum;
  assign ov_count = r_count;
  assign o_ovf    = r_oovf;

endmodule

// File: tb/tb_mult_booth_acc.sv
// Directed bench for mult_booth_acc: a default instance and a GUARD_BITS=1
// instance share all inputs so overflow and count saturation are exercised.
module tb_mult_booth_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [31:0] prod;
  logic        valid;
  logic        last;
  logic        cons_ready;

  logic        ready_a, ovf_a, valid_a;
  logic [39:0] sum_a;
  logic [8:0]  count_a;

  logic        ready_b, ovf_b, valid_b;
  logic [32:0] sum_b;
  logic [1:0]  count_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_booth_acc #(.DATA_WIDTH(16), .GUARD_BITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .iv_prod(prod),
    .i_valid(valid), .i_last(last), .o_ready(ready_a), .ov_sum(sum_a),
    .ov_count(count_a), .o_ovf(ovf_a), .o_valid(valid_a), .i_ready(cons_ready)
  );

  mult_booth_acc #(.DATA_WIDTH(16), .GUARD_BITS(1)) dut_g1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .iv_prod(prod),
    .i_valid(valid), .i_last(last), .o_ready(ready_b), .ov_sum(sum_b),
    .ov_count(count_b), .o_ovf(ovf_b), .o_valid(valid_b), .i_ready(cons_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic l);
    valid = 1'b1;
    prod  = p;
    last  = l;
    step();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic consume();
    cons_ready = 1'b1;
    step();
    cons_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; prod = '0; valid = 1'b0; last = 1'b0; cons_ready = 1'b0;

    // Reset held with clock running
    repeat (3) step();
    check("rst_ready", 64'(ready_a), 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_sum",   64'(sum_a),   64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_ovf",   64'(ovf_a),   64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(ready_a), 64'd0);
    step();
    check("ready_after_edge", 64'(ready_a), 64'd1);

    // Frame 100, -30, 7
    send(32'd100, 1'b0);
    send(-32'sd30, 1'b0);
    send(32'd7, 1'b1);
    check("f1_valid", 64'(valid_a), 64'd1);
    check("f1_sum",   64'(sum_a),   64'd77);
    check("f1_count", 64'(count_a), 64'd3);
    check("f1_ovf",   64'(ovf_a),   64'd0);
    check("f1_ready", 64'(ready_a), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 64'(valid_a), 64'd1);
      check("stall_ready", 64'(ready_a), 64'd0);
      check("stall_sum",   64'(sum_a),   64'd77);
    end
    consume();
    check("f1_drop_valid", 64'(valid_a), 64'd0);
    check("f1_rise_ready", 64'(ready_a), 64'd1);
    check("f1_retain_sum", 64'(sum_a),   64'd77);

    // Single term, most negative product
    send(32'h8000_0000, 1'b1);
    check("single_sum",   64'(sum_a),   64'hFF_8000_0000);
    check("single_count", 64'(count_a), 64'd1);
    check("single_ovf",   64'(ovf_a),   64'd0);
    consume();

    // Overflow with one guard bit; count saturates at 3
    for (int i = 0; i < 4; i++) send(32'h4000_0000, (i == 3));
    check("g1_sum",   64'(sum_b),   64'h1_0000_0000);
    check("g1_ovf",   64'(ovf_b),   64'd1);
    check("g1_count", 64'(count_b), 64'd3);
    check("g8_sum",   64'(sum_a),   64'h01_0000_0000);
    check("g8_ovf",   64'(ovf_a),   64'd0);
    check("g8_count", 64'(count_a), 64'd4);
    consume();
    send(32'd5, 1'b1);
    check("g1_next_ovf", 64'(ovf_b), 64'd0);
    check("g1_next_sum", 64'(sum_b), 64'd5);
    consume();

    // Clear mid-frame discards the i_last product
    send(32'd11, 1'b0);
    send(32'd22, 1'b0);
    clr = 1'b1;
    send(32'd33, 1'b1);
    clr = 1'b0;
    check("clr_valid", 64'(valid_a), 64'd0);
    check("clr_ready", 64'(ready_a), 64'd1);
    check("clr_sum",   64'(sum_a),   64'd5);
    send(32'd5, 1'b1);
    check("post_clr_valid", 64'(valid_a), 64'd1);
    check("post_clr_sum",   64'(sum_a),   64'd5);
    check("post_clr_count", 64'(count_a), 64'd1);
    consume();

    // Backpressure: products offered in HOLD must not be taken
    valid = 1'b1; last = 1'b1; prod = 32'd3;
    step();
    check("bp1_sum", 64'(sum_a), 64'd3);
    prod = 32'd1000;
    step();
    step();
    check("bp_hold_sum",   64'(sum_a),   64'd3);
    check("bp_hold_count", 64'(count_a), 64'd1);
    cons_ready = 1'b1;
    step();
    cons_ready = 1'b0;
    check("bp_release_ready", 64'(ready_a), 64'd1);
    check("bp_release_sum",   64'(sum_a),   64'd3);
    prod = 32'd4;
    step();
    valid = 1'b0; last = 1'b0;
    check("bp2_sum",   64'(sum_a),   64'd4);
    check("bp2_count", 64'(count_a), 64'd1);
    check("bp2_valid", 64'(valid_a), 64'd1);

    // Asynchronous reset mid-HOLD, between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(valid_a), 64'd0);
    check("async_ready", 64'(ready_a), 64'd0);
    check("async_sum",   64'(sum_a),   64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("async_rel_ready", 64'(ready_a), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
